// File: rtl/req_client_pkg.sv
// Shared types and helpers for the four-channel arbiter client.
package req_client_pkg;

    localparam int NCH  = 4;
    localparam int CH_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // True when two or more bits of the vector are set.
    function automatic logic multi_hot(input logic [NCH-1:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            multi = multi | (seen & v[i]);
            seen  = seen | v[i];
        end
        return multi;
    endfunction

    function automatic logic [CH_W-1:0] lowest_index(input logic [NCH-1:0] v);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/req_client_slot.sv
// One channel of the client: holds a single burst job, requests the arbiter,
// counts granted beats and waits for the grant to clear before going idle.
module req_client_slot
    import req_client_pkg::*;
#(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             gnt,
    output logic             idle,
    output logic             req,
    output logic             beat,
    output logic             done,
    output logic             xfer_drop,
    output logic             stall
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    state_t            state, state_next;
    logic [LEN_W-1:0]  cnt, cnt_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              stall_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            wait_cnt <= '0;
            stall    <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            wait_cnt <= wait_next;
            stall    <= stall_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        wait_next  = wait_cnt;
        stall_next = stall;
        req        = 1'b0;
        beat       = 1'b0;
        done       = 1'b0;
        xfer_drop  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    cnt_next   = len;
                    wait_next  = '0;
                    state_next = REQ;
                end
            end
            REQ: begin
                req = 1'b1;
                if (gnt) begin
                    beat      = 1'b1;
                    wait_next = '0;
                    if (cnt == '0) begin
                        state_next = RELEASE;
                    end else begin
                        cnt_next   = cnt - LEN_W'(1);
                        state_next = XFER;
                    end
                end else begin
                    // Saturating wait count; reaching the limit latches the sticky stall.
                    if (wait_cnt != WAIT_MAX) wait_next = wait_cnt + WAIT_W'(1);
                    if (wait_next == WAIT_MAX) stall_next = 1'b1;
                end
            end
            XFER: begin
                req = 1'b1;
                if (gnt) begin
                    beat = 1'b1;
                    if (cnt == '0) begin
                        state_next = RELEASE;
                    end else begin
                        cnt_next = cnt - LEN_W'(1);
                    end
                end else begin
                    xfer_drop = 1'b1;
                end
            end
            RELEASE: begin
                // The arbiter still owns us until its grant falls; a reset here must not report completion.
                if (!gnt) begin
                    done       = ~reset;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign idle = (state == IDLE);

endmodule

// File: rtl/req_client_4ch.sv
// Four-channel requester for the fixed-priority grant arbiter: job demux,
// beat/done reporting and grant-protocol checking around four channel slots.
module req_client_4ch
    import req_client_pkg::*;
#(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [1:0]       job_ch,
    input  logic [LEN_W-1:0] job_len,
    input  logic             gnt_0,
    input  logic             gnt_1,
    input  logic             gnt_2,
    input  logic             gnt_3,
    output logic             req_0,
    output logic             req_1,
    output logic             req_2,
    output logic             req_3,
    output logic             beat_valid,
    output logic [1:0]       beat_ch,
    output logic             done,
    output logic [1:0]       done_ch,
    output logic [3:0]       stall,
    output logic             proto_err
);

    logic [NCH-1:0] gnt;
    logic [NCH-1:0] gnt_q;
    logic [NCH-1:0] start;
    logic [NCH-1:0] idle;
    logic [NCH-1:0] req;
    logic [NCH-1:0] beat_vec;
    logic [NCH-1:0] done_vec;
    logic [NCH-1:0] drop_vec;
    logic           proto_hit;

    assign gnt = {gnt_3, gnt_2, gnt_1, gnt_0};

    for (genvar i = 0; i < NCH; i++) begin : g_slot
        assign start[i] = job_valid && idle[i] && (job_ch == CH_W'(i));

        req_client_slot #(
            .LEN_W   (LEN_W),
            .TIMEOUT (TIMEOUT)
        ) u_slot (
            .clock     (clock),
            .reset     (reset),
            .start     (start[i]),
            .len       (job_len),
            .gnt       (gnt[i]),
            .idle      (idle[i]),
            .req       (req[i]),
            .beat      (beat_vec[i]),
            .done      (done_vec[i]),
            .xfer_drop (drop_vec[i]),
            .stall     (stall[i])
        );
    end

    assign job_ready = idle[job_ch];
    assign req_0     = req[0];
    assign req_1     = req[1];
    assign req_2     = req[2];
    assign req_3     = req[3];

    assign beat_valid = |beat_vec;
    assign beat_ch    = lowest_index(beat_vec);
    assign done       = |done_vec;
    assign done_ch    = lowest_index(done_vec);

    // Overlapping grants, a grant appearing on an idle channel, a grant lost mid-burst,
    // or simultaneous completions can only come from a misbehaving arbiter.
    assign proto_hit = multi_hot(gnt)
                     | (|(gnt & ~gnt_q & idle))
                     | (|drop_vec)
                     | multi_hot(done_vec);

    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_q     <= '0;
            proto_err <= 1'b0;
        end else begin
            gnt_q <= gnt;
            if (proto_hit) proto_err <= 1'b1;
        end
    end

endmodule
